// File: rtl/ss_sgfifo.sv
// 64-bit first-word-fall-through FIFO between the SG reader and its consumer,
// with a registered burst-room flag and a sticky overflow flag.
module ss_sgfifo #(
  parameter int AW       = 4,
  parameter int READY_TH = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wbs_dat_o,
  input  logic [31:0]   wbs_dat64_o,
  input  logic          ss_xfer,
  output logic          ss_ready,
  input  logic          ss_flush,
  output logic [63:0]   dq_dat,
  output logic          dq_valid,
  input  logic          dq_ready,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf_err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TH_C    = (AW+1)'(READY_TH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rdy_q, rdy_d;
  logic          full, push, pop;

  always_comb begin
    full  = (cnt_q == DEPTH_C);
    push  = ss_xfer && !full;
    pop   = (cnt_q != '0) && dq_ready;
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = ovf_q | (ss_xfer & full);
    if (ss_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    // free space after this edge decides whether another burst may start
    rdy_d = (DEPTH_C - cnt_d) >= TH_C;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push && !ss_flush && !wb_rst_i)
      mem_q[wp_q] <= {wbs_dat64_o, wbs_dat_o};
  end

  assign dq_dat   = mem_q[rp_q];
  assign dq_valid = (cnt_q != '0);
  assign fifo_cnt = cnt_q;
  assign ovf_err  = ovf_q;
  assign ss_ready = rdy_q;

endmodule

// File: tb/tb_ss_sgfifo.sv
// Directed and random checks of ss_sgfifo against a queue-based
// reference model.
module tb_ss_sgfifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dat_lo, dat_hi;
  logic        xfer, flush, dqr;
  logic        ss_ready, dq_valid, ovf_err;
  logic [63:0] dq_dat;
  logic [4:0]  fifo_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq[$];
  logic        m_ovf;
  logic        m_rdy;

  always #5 clk = ~clk;

  ss_sgfifo #(.AW(4), .READY_TH(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_dat_o   (dat_lo),
    .wbs_dat64_o (dat_hi),
    .ss_xfer     (xfer),
    .ss_ready    (ss_ready),
    .ss_flush    (flush),
    .dq_dat      (dq_dat),
    .dq_valid    (dq_valid),
    .dq_ready    (dqr),
    .fifo_cnt    (fifo_cnt),
    .ovf_err     (ovf_err)
  );

  function automatic logic [63:0] wd(input int k);
    return {32'(k) + 32'h100, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("cnt", 64'(fifo_cnt), 64'(mq.size()));
    chk("valid", 64'(dq_valid), 64'(mq.size() != 0));
    chk("ready", 64'(ss_ready), 64'(m_rdy));
    chk("ovf", 64'(ovf_err), 64'(m_ovf));
    if (mq.size() != 0) chk("head", dq_dat, mq[0]);
  endtask

  // one clock: drive inputs, advance the model, sample after the edge
  task automatic step(input logic x, input logic [63:0] d, input logic r,
                      input logic f, input logic rs);
    bit was_full;
    bit do_pop;
    @(negedge clk);
    xfer = x; dat_hi = d[63:32]; dat_lo = d[31:0];
    dqr = r; flush = f; rst = rs;
    if (rs || f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (mq.size() == 16);
      do_pop   = (mq.size() != 0) && r;
      if (x && was_full) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (x && !was_full) mq.push_back(d);
    end
    m_rdy = (16 - mq.size()) >= 8;
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int pushed;
    int cyc;
    logic [63:0] w;
    rst = 1'b1; xfer = 1'b0; flush = 1'b0; dqr = 1'b0;
    dat_lo = '0; dat_hi = '0;
    m_ovf = 1'b0; m_rdy = 1'b1;

    // reset ignores other strobes
    step(1'b1, wd(99), 1'b1, 1'b1, 1'b1);
    step(1'b1, wd(98), 1'b0, 1'b0, 1'b1);

    // pass-through
    step(1'b1, 64'h11111111_00000001, 1'b1, 1'b0, 1'b0);
    chk("pt_dat", dq_dat, 64'h11111111_00000001);
    chk("pt_valid", 64'(dq_valid), 64'd1);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("pt_cnt0", 64'(fifo_cnt), 64'd0);

    // threshold
    for (int k = 1; k <= 8; k++) step(1'b1, wd(k), 1'b0, 1'b0, 1'b0);
    chk("th_rdy8", 64'(ss_ready), 64'd1);
    step(1'b1, wd(9), 1'b0, 1'b0, 1'b0);
    chk("th_rdy9", 64'(ss_ready), 64'd0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("th_rdy_pop", 64'(ss_ready), 64'd1);

    // flush beats a simultaneous push
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) step(1'b1, wd(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, wd(50), 1'b1, 1'b1, 1'b0);
    chk("fl_cnt", 64'(fifo_cnt), 64'd0);
    chk("fl_valid", 64'(dq_valid), 64'd0);
    chk("fl_ovf", 64'(ovf_err), 64'd0);
    chk("fl_rdy", 64'(ss_ready), 64'd1);

    // full and overflow, including overflow alongside a pop
    for (int k = 1; k <= 17; k++) step(1'b1, wd(k), 1'b0, 1'b0, 1'b0);
    chk("full_cnt", 64'(fifo_cnt), 64'd16);
    chk("full_ovf", 64'(ovf_err), 64'd1);
    chk("full_head", dq_dat, wd(1));
    step(1'b1, wd(18), 1'b1, 1'b0, 1'b0);
    chk("ovfpop_cnt", 64'(fifo_cnt), 64'd15);
    for (int k = 2; k <= 16; k++) begin
      chk("drain", dq_dat, wd(k));
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(dq_valid), 64'd0);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // simultaneous push/pop at count 5
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b1, wd(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, wd(6), 1'b1, 1'b0, 1'b0);
    chk("pp_cnt", 64'(fifo_cnt), 64'd5);
    chk("pp_head", dq_dat, wd(2));

    // reset mid-operation
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) step(1'b1, wd(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, wd(7), 1'b1, 1'b0, 1'b1);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_valid", 64'(dq_valid), 64'd0);
    chk("rst_rdy", 64'(ss_ready), 64'd1);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    step(1'b1, wd(77), 1'b0, 1'b0, 1'b0);
    chk("rst_first", dq_dat, wd(77));

    // random traffic with wrap-around
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    pushed = 0;
    cyc = 0;
    while (pushed < 40 && cyc < 2000) begin
      logic x;
      x = 1'($urandom_range(1));
      w = {$urandom, $urandom};
      if (x && mq.size() < 16) pushed++;
      step(x, w, 1'($urandom_range(1)), 1'b0, 1'b0);
      chk("rnd_cnt_max", 64'(fifo_cnt <= 5'd16), 64'd1);
      cyc++;
    end
    chk("rnd_budget", 64'(pushed >= 40), 64'd1);
    cyc = 0;
    while (mq.size() != 0 && cyc < 100) begin
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      cyc++;
    end
    chk("rnd_drained", 64'(fifo_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ss_sgfifo.md
SS_SGFIFO -- requirements
Module: ss_sgfifo

Interface
REQ-001 Parameter AW, default 4: log2 of FIFO depth, so DEPTH = 2^AW = 16 entries of 64 bits.
REQ-002 Parameter READY_TH, default 8: minimum free entries for ss_ready; legal range 1..DEPTH.
REQ-003 wb_clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-005 wbs_dat_o  input  32  low word of the bus read data, captured on ss_xfer.
REQ-006 wbs_dat64_o  input  32  high word of the bus read data, captured on ss_xfer.
REQ-007 ss_xfer  input  1  write strobe from the SG reader, one 64-bit beat per asserted cycle.
REQ-008 ss_ready  output  1  room for a burst; gates the SG reader leaving its wait state.
REQ-009 ss_flush  input  1  synchronous clear of the FIFO contents.
REQ-010 dq_dat  output  64  head-of-FIFO data, equal to {wbs_dat64_o, wbs_dat_o} as written.
REQ-011 dq_valid  output  1  dq_dat holds a valid word.
REQ-012 dq_ready  input  1  consumer accepts the word; a pop occurs when dq_valid && dq_ready.
REQ-013 fifo_cnt  output  AW+1  number of occupied entries, 0..DEPTH.
REQ-014 ovf_err  output  1  sticky flag: a write was attempted while the FIFO was full.

Function
REQ-015 Storage: circular buffer with write pointer wp and read pointer rp (AW bits each) that wrap from DEPTH-1 to 0, and a count register of AW+1 bits.
REQ-016 Push: when ss_xfer=1 and count<DEPTH, mem[wp] takes {wbs_dat64_o, wbs_dat_o}, and wp increments by 1 modulo DEPTH.
REQ-017 Push while full: when ss_xfer=1 and count==DEPTH, the data is dropped, pointers are unchanged, and ovf_err is set to 1 on the next edge; this applies even if a pop occurs in the same cycle.
REQ-018 Pop: when dq_valid=1 and dq_ready=1, rp increments by 1 modulo DEPTH.
REQ-019 Count: count_next = count + push - pop, where push/pop are the accepted operations; a simultaneous push and pop leaves the count unchanged.
REQ-020 The FIFO is first-word-fall-through: dq_valid = (count != 0) and dq_dat = mem[rp], both driven combinationally from registers.
REQ-021 Latency: a word pushed at edge N appears on dq_dat/dq_valid after edge N, and is therefore visible in cycle N+1 when the FIFO was empty.
REQ-022 When count==0, dq_dat is don't-care and the bench must not check it.
REQ-023 A pop when empty cannot occur because dq_valid=0; dq_ready is ignored in that case.
REQ-024 ss_ready is a register loaded each edge with ((DEPTH - count_next) >= READY_TH).
REQ-025 ss_ready deasserts on the same edge at which free space drops below READY_TH.
REQ-026 Words pushed after ss_ready deasserts (the tail of an in-flight burst) are still accepted up to DEPTH.
REQ-027 fifo_cnt equals the count register.
REQ-028 Flush: ss_flush=1 sets wp, rp and count to 0, clears ovf_err, and sets ss_ready to 1 on the next edge.
REQ-029 Flush has priority over any simultaneous push or pop; the data presented during a flush cycle is discarded.
REQ-030 ovf_err holds its value until ss_flush or reset.
REQ-031 Ordering: words leave the FIFO in exactly the order they were pushed, including across pointer wrap-around.

Reset
REQ-032 While wb_rst_i=1 at an edge: wp=0, rp=0, count=0, ovf_err=0, ss_ready=1 and dq_valid=0, regardless of ss_xfer, dq_ready or ss_flush.
REQ-033 Storage contents are not reset.
REQ-034 Reset asserted mid-burst discards all stored words.
REQ-035 The first push is accepted on the first edge after wb_rst_i returns to 0.

Verification
REQ-036 Basic pass-through: after reset, push 0x11111111_00000001 at edge 1 with dq_ready=1 -> dq_valid=1 in cycle 2 with that value; fifo_cnt returns to 0 after edge 2.
REQ-037 Threshold: with dq_ready=0, push 8 words -> ss_ready=1 after edge 8; push a 9th word -> ss_ready=0 after edge 9; pop 1 word -> ss_ready=1 again.
REQ-038 Full and overflow: with dq_ready=0, push 17 words -> fifo_cnt=16 and ovf_err=1; draining returns exactly words 1..16 in order, and the 17th word is absent.
REQ-039 Wrap and concurrency: run 40 words through with ss_xfer and dq_ready both random at 50% -> output order matches input order, and fifo_cnt never exceeds 16 and never goes below 0.
REQ-040 Simultaneous push/pop at count=5 -> count stays 5, and the head advances to the next word.
REQ-041 Flush vs push: ss_flush=1 together with ss_xfer=1 at count=3 -> after the edge, fifo_cnt=0, dq_valid=0, ovf_err=0 and ss_ready=1.
REQ-042 Reset mid-operation: assert wb_rst_i at count=3 -> after the edge, fifo_cnt=0, dq_valid=0, ss_ready=1 and ovf_err=0.
